// File: rtl/vp_lvp_if.sv
// Lookup, prediction and feedback bundle between the VP table and the
// decode/commit stages.
interface vp_lvp_if #(
  parameter int LANES  = 2,
  parameter int CONF_W = 3
);
  logic [LANES-1:0]        lookup_valid;
  logic [LANES*31-1:0]     lookup_pc;
  logic [LANES-1:0]        pred_valid;
  logic [LANES*32-1:0]     pred_value;
  logic [LANES-1:0]        pred_conf;
  logic [LANES*CONF_W-1:0] pred_ctr;
  logic                    fb_valid;
  logic [31:0]             fb_pc;
  logic [31:0]             fb_actual;
  logic                    fb_misp;

  modport master (
    output lookup_valid, lookup_pc, fb_valid, fb_pc, fb_actual, fb_misp,
    input  pred_valid, pred_value, pred_conf, pred_ctr
  );

  modport slave (
    input  lookup_valid, lookup_pc, fb_valid, fb_pc, fb_actual, fb_misp,
    output pred_valid, pred_value, pred_conf, pred_ctr
  );
endinterface

// File: rtl/vp_lvp_table.sv
// Last-value prediction table: LANES registered lookups, commit-time training,
// and a self-timed walk that invalidates every entry at reset and on flush.
module vp_lvp_table #(
  parameter int ENTRIES     = 64,
  parameter int TAG_W       = 8,
  parameter int CONF_W      = 3,
  parameter int CONF_THRESH = 7,
  parameter int LANES       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vp_en,
  input  logic         flush,
  output logic         busy,
  vp_lvp_if.slave      lvp
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam logic [CONF_W-1:0] THRESH   = CONF_W'(CONF_THRESH);
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(ENTRIES - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] clr_idx_q, clr_idx_d;

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        val_mem [ENTRIES];
  logic [CONF_W-1:0]  ctr_mem [ENTRIES];

  logic [IDXW-1:0]  fb_idx;
  logic [TAG_W-1:0] fb_tag;
  logic             fb_hit, fb_same, train_en;

  logic [IDXW-1:0]  lk_idx [LANES];
  logic [LANES-1:0] lk_hit;

  logic [LANES-1:0]        pv_q;
  logic [LANES*32-1:0]     pval_q;
  logic [LANES-1:0]        pconf_q;
  logic [LANES*CONF_W-1:0] pctr_q;

  // Only the index/tag window of each PC is looked at.
  logic unused_ok;
  assign unused_ok = ^{lvp.fb_pc, lvp.lookup_pc};

  assign busy = (state_q == S_CLEAR);

  // Clear walk FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
        end
      end
      S_CLEAR: begin
        if (flush) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == LAST_IDX) begin
          state_d   = S_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // Feedback decode and training
  assign fb_idx   = lvp.fb_pc[IDXW:1];
  assign fb_tag   = lvp.fb_pc[IDXW+TAG_W:IDXW+1];
  assign fb_hit   = vld_q[fb_idx] && (tag_mem[fb_idx] == fb_tag);
  assign fb_same  = fb_hit && (lvp.fb_actual == val_mem[fb_idx]) && !lvp.fb_misp;
  assign train_en = lvp.fb_valid && vp_en && !busy && !rst;

  // Valid bits are the only state the walk touches; training never overlaps it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        vld_q[clr_idx_q] <= 1'b0;
      end else if (train_en) begin
        vld_q[fb_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (train_en) begin
      if (fb_same) begin
        if (ctr_mem[fb_idx] != '1) begin
          ctr_mem[fb_idx] <= ctr_mem[fb_idx] + 1'b1;
        end
      end else begin
        tag_mem[fb_idx] <= fb_tag;
        val_mem[fb_idx] <= lvp.fb_actual;
        ctr_mem[fb_idx] <= '0;
      end
    end
  end

  // Lookup
  always_comb begin
    lk_hit = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lk_idx[l] = lvp.lookup_pc[l*31 +: IDXW];
      lk_hit[l] = lvp.lookup_valid[l] && vp_en && !busy && vld_q[lk_idx[l]] &&
                  (tag_mem[lk_idx[l]] == lvp.lookup_pc[l*31+IDXW +: TAG_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q    <= '0;
      pval_q  <= '0;
      pconf_q <= '0;
      pctr_q  <= '0;
    end else begin
      for (int unsigned l = 0; l < LANES; l++) begin
        pv_q[l] <= lk_hit[l];
        if (lk_hit[l]) begin
          pval_q[l*32 +: 32]        <= val_mem[lk_idx[l]];
          pctr_q[l*CONF_W +: CONF_W] <= ctr_mem[lk_idx[l]];
          pconf_q[l]                 <= (ctr_mem[lk_idx[l]] >= THRESH);
        end else begin
          pval_q[l*32 +: 32]        <= '0;
          pctr_q[l*CONF_W +: CONF_W] <= '0;
          pconf_q[l]                 <= 1'b0;
        end
      end
    end
  end

  assign lvp.pred_valid = pv_q;
  assign lvp.pred_value = pval_q;
  assign lvp.pred_conf  = pconf_q;
  assign lvp.pred_ctr   = pctr_q;

endmodule

// File: tb/tb_vp_lvp_table.sv
// Bench for vp_lvp_table: directed scenarios plus random traffic, all checked
// against a table model updated from the prediction rules each cycle.
module tb_vp_lvp_table;
  localparam int ENTRIES     = 64;
  localparam int TAG_W       = 8;
  localparam int CONF_W      = 3;
  localparam int CONF_THRESH = 7;
  localparam int LANES       = 2;
  localparam int IDXW        = $clog2(ENTRIES);
  localparam int CTR_MAX     = (1 << CONF_W) - 1;

  logic clk = 1'b0;
  logic rst, vp_en, flush, busy;

  vp_lvp_if #(.LANES(LANES), .CONF_W(CONF_W)) ifc ();

  vp_lvp_table #(
    .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CONF_W(CONF_W),
    .CONF_THRESH(CONF_THRESH), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .vp_en(vp_en), .flush(flush), .busy(busy), .lvp(ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_val   [ENTRIES];
  int unsigned m_ctr   [ENTRIES];
  int          m_busy_left = 0;
  logic [31:0] lk_pc   [LANES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned pidx(input logic [31:0] pc);
    return (pc >> 1) % ENTRIES;
  endfunction

  function automatic int unsigned ptag(input logic [31:0] pc);
    return (pc >> (IDXW + 1)) % (1 << TAG_W);
  endfunction

  // One clock: predict outputs from the model, apply the edge, compare.
  task automatic step();
    bit          e_pv  [LANES];
    logic [31:0] e_val [LANES];
    int unsigned e_ctr [LANES];
    int unsigned i, t;
    for (int l = 0; l < LANES; l++) begin
      ifc.lookup_pc[l*31 +: 31] = lk_pc[l][31:1];
      e_pv[l] = 1'b0; e_val[l] = '0; e_ctr[l] = 0;
      if (!rst && vp_en && m_busy_left == 0 && ifc.lookup_valid[l]) begin
        i = pidx(lk_pc[l]);
        if (m_valid[i] && m_tag[i] == ptag(lk_pc[l])) begin
          e_pv[l] = 1'b1; e_val[l] = m_val[i]; e_ctr[l] = m_ctr[i];
        end
      end
    end
    if (!rst && ifc.fb_valid && vp_en && m_busy_left == 0) begin
      i = pidx(ifc.fb_pc);
      t = ptag(ifc.fb_pc);
      if (m_valid[i] && m_tag[i] == t) begin
        if (ifc.fb_actual == m_val[i] && !ifc.fb_misp) begin
          if (m_ctr[i] < CTR_MAX) m_ctr[i]++;
        end else begin
          m_val[i] = ifc.fb_actual; m_ctr[i] = 0;
        end
      end else begin
        m_valid[i] = 1'b1; m_tag[i] = t; m_val[i] = ifc.fb_actual; m_ctr[i] = 0;
      end
    end
    if (rst || flush) begin
      m_busy_left = ENTRIES;
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < LANES; l++) begin
      check($sformatf("pred_valid%0d", l), 32'(ifc.pred_valid[l]), 32'(e_pv[l]));
      check($sformatf("pred_value%0d", l), ifc.pred_value[l*32 +: 32], e_val[l]);
      check($sformatf("pred_ctr%0d", l), 32'(ifc.pred_ctr[l*CONF_W +: CONF_W]), e_ctr[l]);
      check($sformatf("pred_conf%0d", l), 32'(ifc.pred_conf[l]),
            32'(e_pv[l] && e_ctr[l] >= CONF_THRESH));
    end
    check("busy", 32'(busy), 32'(m_busy_left > 0));
  endtask

  task automatic idle_inputs();
    ifc.lookup_valid = '0;
    ifc.fb_valid     = 1'b0;
    ifc.fb_misp      = 1'b0;
    flush            = 1'b0;
  endtask

  task automatic do_fb(input logic [31:0] pc, input logic [31:0] act, input logic misp);
    ifc.fb_valid = 1'b1; ifc.fb_pc = pc; ifc.fb_actual = act; ifc.fb_misp = misp;
    step();
    idle_inputs();
  endtask

  task automatic do_lookup(input logic [31:0] pc0, input logic [31:0] pc1,
                           input logic [LANES-1:0] v);
    lk_pc[0] = pc0; lk_pc[1] = pc1; ifc.lookup_valid = v;
    step();
    idle_inputs();
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  int cnt;

  initial begin
    rst = 1'b1; vp_en = 1'b1;
    ifc.lookup_pc = '0; ifc.fb_pc = '0; ifc.fb_actual = '0;
    lk_pc[0] = '0; lk_pc[1] = '0;
    idle_inputs();
    step();
    step();
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_pred_valid", 32'(ifc.pred_valid), 32'd0);
    rst = 1'b0;

    // Power-up walk length
    wait_idle(cnt);
    check("busy_cycles_reset", cnt, 64);
    do_lookup(32'h0000_1000, 32'h0000_2F3E, 2'b11);
    check("empty_lookup", 32'(ifc.pred_valid), 32'd0);

    // Training and confidence threshold
    for (int k = 0; k < 7; k++) do_fb(32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    do_lookup(32'h0000_1000, 32'h0, 2'b01);
    check("t2_ctr6", 32'(ifc.pred_ctr[CONF_W-1:0]), 32'd6);
    check("t2_conf0", 32'(ifc.pred_conf[0]), 32'd0);
    do_fb(32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    do_lookup(32'h0000_1000, 32'h0, 2'b01);
    check("t2_value", ifc.pred_value[31:0], 32'hDEAD_BEEF);
    check("t2_ctr7", 32'(ifc.pred_ctr[CONF_W-1:0]), 32'd7);
    check("t2_conf1", 32'(ifc.pred_conf[0]), 32'd1);

    // Mispredict resets the entry
    do_fb(32'h0000_1000, 32'h0000_1234, 1'b1);
    do_lookup(32'h0000_1000, 32'h0, 2'b01);
    check("t3_value", ifc.pred_value[31:0], 32'h0000_1234);
    check("t3_ctr", 32'(ifc.pred_ctr[CONF_W-1:0]), 32'd0);

    // Aliasing: same index, different tag
    do_fb(32'h0000_1080, 32'h0000_5555, 1'b0);
    do_lookup(32'h0000_1000, 32'h0000_1080, 2'b11);
    check("t4_evicted", 32'(ifc.pred_valid[0]), 32'd0);
    check("t4_alloc", 32'(ifc.pred_valid[1]), 32'd1);
    check("t4_ctr", 32'(ifc.pred_ctr[2*CONF_W-1:CONF_W]), 32'd0);

    // Same-cycle feedback and lookup see pre-update contents
    for (int k = 0; k < 4; k++) do_fb(32'h0000_2000, 32'h0000_00AA, 1'b0);
    ifc.fb_valid = 1'b1; ifc.fb_pc = 32'h0000_2000; ifc.fb_actual = 32'h0000_00AA;
    do_lookup(32'h0000_2000, 32'h0000_2000, 2'b11);
    check("t5_lane0", 32'(ifc.pred_ctr[CONF_W-1:0]), 32'd3);
    check("t5_lane1", 32'(ifc.pred_ctr[2*CONF_W-1:CONF_W]), 32'd3);
    do_lookup(32'h0000_2000, 32'h0, 2'b01);
    check("t5_next", 32'(ifc.pred_ctr[CONF_W-1:0]), 32'd4);

    // Flush restart mid-walk, feedback dropped while busy, second flush
    do_fb(32'h0000_3000, 32'h0000_0777, 1'b0);
    do_lookup(32'h0000_3000, 32'h0, 2'b01);
    check("t6_pre", 32'(ifc.pred_valid[0]), 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) do_fb(32'h0000_3000, 32'h0000_0777, 1'b0);
      else step();
    end
    flush = 1'b1; step(); flush = 1'b0;
    wait_idle(cnt);
    check("busy_cycles_flush1", cnt, 64);
    do_lookup(32'h0000_3000, 32'h0, 2'b01);
    check("t6_cleared", 32'(ifc.pred_valid[0]), 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    wait_idle(cnt);
    check("busy_cycles_flush2", cnt, 64);

    // vp_en low: no predictions, no training
    do_fb(32'h0000_4000, 32'h1, 1'b0);
    vp_en = 1'b0;
    do_fb(32'h0000_4000, 32'h2, 1'b1);
    do_lookup(32'h0000_4000, 32'h0000_4000, 2'b11);
    check("en_off", 32'(ifc.pred_valid), 32'd0);
    vp_en = 1'b1;
    do_lookup(32'h0000_4000, 32'h0, 2'b01);
    check("en_on_value", ifc.pred_value[31:0], 32'h1);

    // Random traffic over a small aliasing working set
    for (int c = 0; c < 4000; c++) begin
      for (int l = 0; l < LANES; l++) begin
        lk_pc[l] = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 3)) << (IDXW + 1)) |
                   (32'($urandom_range(0, 7)) << 1) | 32'($urandom_range(0, 1));
      end
      ifc.lookup_valid = LANES'($urandom);
      ifc.fb_valid  = ($urandom_range(0, 2) != 0);
      ifc.fb_pc     = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 3)) << (IDXW + 1)) |
                      (32'($urandom_range(0, 7)) << 1) | 32'($urandom_range(0, 1));
      ifc.fb_actual = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1));
      ifc.fb_misp   = ($urandom_range(0, 15) == 0);
      flush         = ($urandom_range(0, 299) == 0);
      vp_en         = ($urandom_range(0, 15) != 0);
      rst           = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
